ram_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port synchronous RAM between NREQ requesters, such as the FIFO write side, the FIFO read side, and the LIFO push/pop ports.
- Issues at most one RAM access per cycle.
- Steers read data back to the originating requester with a valid strobe.
- Sits between the queue controllers and the RAM instance; it replaces direct muxing of the RAM address and data lines.

---
 rtl/ram_rr_arbiter.sv | 105 ++++++++++
 tb/tb_ram_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: round-robin arbiter sharing one single-port synchronous RAM among NREQ requesters
// Define ARB_LOCK_EN to let a requester hold the grant for bursts of up to MAX_BURST cycles.
module ram_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_dataIn,
    output logic                     mem_write_enable,
    input  logic [DATA_W-1:0]        mem_dataOut,
    output logic                     busy
);
    localparam int PW = $clog2(NREQ);
`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif
    state_t            state, state_n;
    logic [PW-1:0]     rr_ptr, rr_n, rw, w;
    logic              granted;
    logic [NREQ-1:0]   rv_q;
    logic [ADDR_W-1:0] addr_a  [NREQ];
    logic [DATA_W-1:0] wdata_a [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    end
    // Scan downwards so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        rw = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(rr_ptr) + k) % NREQ]) rw = PW'((int'(rr_ptr) + k) % NREQ);
    end
`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);
    logic [PW-1:0] owner;
    logic [CW-1:0] cnt;
    logic          no_relock, held, keep, forced, lock_enter;
    assign held       = state == LOCKED && req[owner] && req_lock[owner];
    assign keep       = held && cnt < MAXB;
    assign forced     = held && cnt == MAXB;
    assign w          = keep ? owner : rw;
    assign granted    = !reset && (keep || |req);
    // A forcibly released owner may be granted again but not re-locked until someone else is served.
    assign lock_enter = granted && !keep && req_lock[w] && !((no_relock || forced) && w == owner);
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= '0;
            cnt       <= '0;
            no_relock <= 1'b0;
        end else begin
            owner     <= lock_enter ? w : owner;
            cnt       <= keep ? cnt + 1'b1 : lock_enter ? CW'(1) : cnt;
            no_relock <= (granted && w != owner) ? 1'b0 : forced ? 1'b1 : no_relock;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock ^ (MAX_BURST > 0);
    assign w           = rw;
    assign granted     = !reset && |req;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            rv_q   <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_n;
            rv_q   <= (granted && !req_we[w]) ? gnt : '0;
        end
    end
    always_comb begin
`ifdef ARB_LOCK_EN
        state_n = (keep || lock_enter) ? LOCKED : |req ? GRANT : IDLE;
`else
        state_n = |req ? GRANT : IDLE;
`endif
        rr_n = granted ? (w == PW'(NREQ - 1) ? '0 : w + 1'b1) : rr_ptr;
    end
    always_comb begin
        gnt              = granted ? (NREQ'(1) << w) : '0;
        busy             = granted;
        mem_addr         = granted ? addr_a[w] : '0;
        mem_dataIn       = granted ? wdata_a[w] : '0;
        mem_write_enable = granted && req_we[w];
        rvalid           = reset ? '0 : rv_q;
        rdata            = |rvalid ? mem_dataOut : '0;
    end
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: directed bench for ram_rr_arbiter with a synchronous RAM model
module tb_ram_rr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, req_we, req_lock, gnt, rvalid;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  rdata, mem_addr, mem_dataIn, mem_dataOut;
    logic        mem_write_enable, busy;
    logic [7:0]  ram [256];
    bit          ram_valid [256];
    int          pass_cnt = 0;
    int          total = 0;

    ram_rr_arbiter #(.NREQ(4), .ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_write_enable(mem_write_enable),
        .mem_dataOut(mem_dataOut), .busy(busy)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back as addr ^ 0x3C.
    always @(posedge clk) begin
        if (mem_write_enable) begin
            ram[mem_addr]       <= mem_dataIn;
            ram_valid[mem_addr] <= 1'b1;
        end
        mem_dataOut <= ram_valid[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'h3C);
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        reset = 1'b1; req = 4'b1111; req_we = 4'b1111;
        #1;
        total++;
        if ({gnt, busy, mem_write_enable, rvalid, rdata} !== 18'd0)
            $display("FAIL reset_with_req gnt=%b busy=%b we=%b rvalid=%b rdata=%h expected all zero",
                     gnt, busy, mem_write_enable, rvalid, rdata);
        else pass_cnt++;
        tick;
        reset = 1'b0; req = 4'b0000; req_we = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({gnt, busy, mem_write_enable, rvalid} !== 10'd0)
                $display("FAIL idle_cycle%0d gnt=%b busy=%b we=%b rvalid=%b expected all zero",
                         i, gnt, busy, mem_write_enable, rvalid);
            else pass_cnt++;
            tick;
        end
    endtask

    task test_write_read;
        req = 4'b0010; req_we = 4'b0010; req_addr[15:8] = 8'h10; req_wdata[15:8] = 8'hA5;
        #1;
        total++;
        if ({gnt, busy, mem_write_enable, mem_addr, mem_dataIn} !== {4'b0010, 1'b1, 1'b1, 8'h10, 8'hA5})
            $display("FAIL write_strobe gnt=%b busy=%b we=%b addr=%h din=%h expected 0010 1 1 10 a5",
                     gnt, busy, mem_write_enable, mem_addr, mem_dataIn);
        else pass_cnt++;
        tick;
        req_we = 4'b0000;
        #1;
        total++;
        if ({gnt, mem_write_enable, mem_addr, rvalid} !== {4'b0010, 1'b0, 8'h10, 4'b0000})
            $display("FAIL read_strobe gnt=%b we=%b addr=%h rvalid=%b expected 0010 0 10 0000",
                     gnt, mem_write_enable, mem_addr, rvalid);
        else pass_cnt++;
        tick;
        req = 4'b0000;
        #1;
        total++;
        if ({rvalid, rdata, gnt} !== {4'b0010, 8'hA5, 4'b0000})
            $display("FAIL read_return rvalid=%b rdata=%h gnt=%b expected 0010 a5 0000", rvalid, rdata, gnt);
        else pass_cnt++;
        tick;
    endtask

    task test_round_robin;
        logic [3:0] eg, ev;
        logic [7:0] ed;
        reset = 1'b1;
        tick;
        reset = 1'b0; req = 4'b1111; req_we = 4'b0000;
        for (int i = 0; i < 4; i++) req_addr[i*8 +: 8] = 8'(8'h20 + i);
        for (int c = 0; c < 8; c++) begin
            #1;
            eg = 4'b0001 << (c % 4);
            ev = (c == 0) ? 4'b0000 : 4'b0001 << ((c - 1) % 4);
            ed = (c == 0) ? 8'h00 : 8'(8'h20 + (c - 1) % 4) ^ 8'h3C;
            total++;
            if ({gnt, rvalid, rdata} !== {eg, ev, ed})
                $display("FAIL rr_cycle%0d gnt=%b rvalid=%b rdata=%h expected %b %b %h", c, gnt, rvalid, rdata, eg, ev, ed);
            else pass_cnt++;
            tick;
        end
        req = 4'b0000;
        #1;
        total++;
        if ({rvalid, rdata} !== {4'b1000, 8'h23 ^ 8'h3C})
            $display("FAIL rr_last_return rvalid=%b rdata=%h expected 1000 1f", rvalid, rdata);
        else pass_cnt++;
        tick;
    endtask

    task test_pattern;
        logic [3:0] exp [3];
        exp = '{4'b0100, 4'b0001, 4'b0100};
        reset = 1'b1;
        tick;
        reset = 1'b0; req = 4'b0001; req_we = 4'b0000;
        #1;
        total++;
        if (gnt !== 4'b0001) $display("FAIL pattern_setup gnt=%b expected 0001", gnt);
        else pass_cnt++;
        tick;
        req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (gnt !== exp[c]) $display("FAIL pattern_0101_step%0d gnt=%b expected %b", c, gnt, exp[c]);
            else pass_cnt++;
            tick;
        end
        req = 4'b1101;
        #1;
        total++;
        if (gnt !== 4'b1000) $display("FAIL pattern_late_req3 gnt=%b expected 1000", gnt);
        else pass_cnt++;
        tick;
        #1;
        total++;
        if (gnt !== 4'b0001) $display("FAIL pattern_wrap gnt=%b expected 0001", gnt);
        else pass_cnt++;
        tick;
        req = 4'b0000;
    endtask

    task test_single;
        req = 4'b0100; req_we = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (gnt !== 4'b0100) $display("FAIL single_cycle%0d gnt=%b expected 0100", c, gnt);
            else pass_cnt++;
            tick;
        end
        req = 4'b0000;
        tick;
    endtask

    task test_reset_inflight;
        req = 4'b0010; req_we = 4'b0000;
        #1;
        total++;
        if (gnt !== 4'b0010) $display("FAIL inflight_grant gnt=%b expected 0010", gnt);
        else pass_cnt++;
        tick;
        reset = 1'b1; req = 4'b0000;
        #1;
        total++;
        if ({rvalid, rdata} !== 12'd0) $display("FAIL inflight_during_reset rvalid=%b rdata=%h expected 0000 00", rvalid, rdata);
        else pass_cnt++;
        tick;
        reset = 1'b0; req = 4'b1111;
        #1;
        total++;
        if ({rvalid, gnt} !== {4'b0000, 4'b0001})
            $display("FAIL inflight_after_reset rvalid=%b gnt=%b expected 0000 0001", rvalid, gnt);
        else pass_cnt++;
        tick;
        req = 4'b0000;
        tick;
    endtask

    task test_lock;
        logic [3:0] exp [7];
`ifdef ARB_LOCK_EN
        exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`else
        exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        reset = 1'b1;
        tick;
        reset = 1'b0; req = 4'b0011; req_lock = 4'b0001; req_we = 4'b0000;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) req_lock = 4'b0000;
            #1;
            total++;
            if (gnt !== exp[c]) $display("FAIL lock_cycle%0d gnt=%b expected %b", c, gnt, exp[c]);
            else pass_cnt++;
            tick;
        end
        req = 4'b0000; req_lock = 4'b0000;
        tick;
    endtask

    initial begin
        reset = 1'b1; req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        tick;
        test_reset;
        test_write_read;
        test_round_robin;
        test_pattern;
        test_single;
        test_reset_inflight;
        test_lock;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
